fpio_fifo_mc: RTL and testbench
===============================

# fpio_fifo_mc

Multi-channel successor to the single-channel FPIO FIFO. It holds NUM_CHANNELS independent FIFOs of 2^FIFO_BITS entries each in one shared dual-port RAM, with one push port and one pop port that each carry a channel select. The block adds what the single-channel FIFO lacks: full/empty protection with error reporting, per-channel flush, almost-full/almost-empty flags and sticky overflow/underflow status. It sits between the FPIO pin-sampling logic (producer) and the bus-side register block (consumer).

## Interface
- FIFO_BITS, 4: log2 of depth per channel; DEPTH = 2^FIFO_BITS.
- DATA_WIDTH, 32: entry width.
- NUM_CHANNELS, 4: number of channels; CH_BITS = max(1, $clog2(NUM_CHANNELS)).
- AF_LEVEL, DEPTH-2: almost-full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost-empty asserts when count <= AE_LEVEL.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_data_en  in  1  push request, one cycle per entry.
- in_chan  in  CH_BITS  push channel.
- in_data  in  DATA_WIDTH  push data.
- in_data_ack  out  1  push completed, one cycle after in_data_en.
- in_err  out  1  qualifies in_data_ack; push was rejected.
- out_data_en  in  1  pop request.
- out_chan  in  CH_BITS  pop channel.
- out_data  out  DATA_WIDTH  popped entry; valid only while out_data_ack is high.
- out_data_ack  out  1  pop completed, one cycle after out_data_en.
- out_err  out  1  qualifies out_data_ack; pop was rejected.
- flush  in  NUM_CHANNELS  per-channel synchronous clear.
- count  out  NUM_CHANNELS*(FIFO_BITS+1)  per-channel occupancy; channel c is at bits [c*(FIFO_BITS+1) +: FIFO_BITS+1].
- full, empty, afull, aempty  out  NUM_CHANNELS each  per-channel flags, decoded from count.
- ovf, unf  out  NUM_CHANNELS each  sticky overflow and underflow.

## Operation
- Per channel: wr_ptr[FIFO_BITS-1:0], rd_ptr[FIFO_BITS-1:0], cnt[FIFO_BITS:0]. RAM address is {chan, ptr}. Total RAM size is NUM_CHANNELS*DEPTH words, with a registered read.
- Push accept rule: in_data_en && !full[in_chan] && !flush[in_chan].
  - Accepted: write RAM[{in_chan, wr_ptr}], then wr_ptr+1 (wraps modulo DEPTH), cnt+1.
  - Rejected: no state change, ovf[in_chan] is set, in_err=1 with the ack.
- Pop accept rule: out_data_en && !empty[out_chan] && !flush[out_chan].
  - Accepted: read RAM[{out_chan, rd_ptr}], then rd_ptr+1, cnt-1.
  - Rejected: unf[out_chan] is set, out_err=1, out_data=0.
- Full/empty are evaluated on the count before the cycle. A push to an empty channel and a pop from that channel in the same cycle give: push accepted, pop rejected.
- Same-channel push and pop both accepted: cnt unchanged, both pointers advance. No RAM address collision is possible in this case.
- Flush[c] clears wr_ptr, rd_ptr, cnt, ovf and unf for channel c. It takes priority over a same-cycle push or pop to c; that push or pop is rejected but does not set ovf/unf.
- Push and pop to different channels are fully independent.
- Reset values:
  - All pointers, counts, ovf, unf, in_data_ack, in_err, out_data_ack, out_err and out_data are 0.
  - empty and aempty are all-1; full and afull are all-0.
- en asserted during rst is ignored and produces no ack.

## Timing
- Request sampled at edge T. RAM, pointers, counts and sticky flags update at edge T.
- Ack, err and out_data are registered and valid in cycle T+1 for exactly one cycle.
- Back-to-back: en may be held for consecutive cycles. That gives one transfer per cycle, with each ack trailing its request by one cycle.
- count and the flags reflect edge T in cycle T+1, the same cycle as the ack.
- A pop issued in the cycle immediately after the push that filled the entry returns that data. There is no read-after-write bubble.

## Test plan
- Reset, then push 0xA0..0xA3 on ch1, then pop ch1 four times -> acks each one cycle after en, out_data A0,A1,A2,A3 in order, count[1] back to 0, empty[1]=1.
- Fill ch0 with DEPTH pushes, then push one more with 0xDEAD -> full[0]=1, the extra push returns in_err=1, ovf[0]=1, and DEPTH pops return the original data without 0xDEAD.
- Pop an empty ch2 -> out_err=1, out_data=0, unf[2]=1, no pointer movement. Then flush[2] -> unf[2]=0.
- Same cycle push ch3 and pop ch3 with count[3]=3 -> count stays 3, popped data is the oldest entry. Then 2*DEPTH alternating push/pop on ch3 exercises pointer wrap with data intact.
- Interleave pushes on ch0/ch1, then pop them -> no cross-channel corruption. afull/aempty toggle at AF_LEVEL/AE_LEVEL exactly.
- Assert rst mid-stream with ch0 holding 5 entries -> next cycle all counts are 0, acks are 0 and empty is all-1.

Source files
------------

// File: rtl/fpio_fifo_mc.sv
// Multi-channel FIFO: NUM_CHANNELS independent FIFOs sharing one dual-port RAM,
// with one push port and one pop port, each steered by a channel select.
module fpio_fifo_mc #(
    parameter int FIFO_BITS    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int AF_LEVEL     = (1 << FIFO_BITS) - 2,
    parameter int AE_LEVEL     = 2,
    localparam int CH_BITS     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_data_en,
    input  logic [CH_BITS-1:0]                    in_chan,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  in_data_ack,
    output logic                                  in_err,
    input  logic                                  out_data_en,
    input  logic [CH_BITS-1:0]                    out_chan,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_data_ack,
    output logic                                  out_err,
    input  logic [NUM_CHANNELS-1:0]               flush,
    output logic [NUM_CHANNELS*(FIFO_BITS+1)-1:0] count,
    output logic [NUM_CHANNELS-1:0]               full,
    output logic [NUM_CHANNELS-1:0]               empty,
    output logic [NUM_CHANNELS-1:0]               afull,
    output logic [NUM_CHANNELS-1:0]               aempty,
    output logic [NUM_CHANNELS-1:0]               ovf,
    output logic [NUM_CHANNELS-1:0]               unf
);

    localparam int DEPTH     = 1 << FIFO_BITS;
    localparam int CNT_W     = FIFO_BITS + 1;
    localparam int ADDR_W    = CH_BITS + FIFO_BITS;
    localparam int RAM_WORDS = NUM_CHANNELS * DEPTH;

    logic [FIFO_BITS-1:0]    w_wr_ptr [NUM_CHANNELS];
    logic [FIFO_BITS-1:0]    w_rd_ptr [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_full;
    logic [NUM_CHANNELS-1:0] w_empty;
    logic [NUM_CHANNELS-1:0] w_push_sel;
    logic [NUM_CHANNELS-1:0] w_pop_sel;
    logic [NUM_CHANNELS-1:0] w_push_ok_vec;
    logic [NUM_CHANNELS-1:0] w_pop_ok_vec;
    logic                    w_push_ok;
    logic                    w_pop_ok;
    logic [FIFO_BITS-1:0]    w_wr_ptr_sel;
    logic [FIFO_BITS-1:0]    w_rd_ptr_sel;
    logic [ADDR_W-1:0]       w_wr_addr;
    logic [ADDR_W-1:0]       w_rd_addr;

    logic [DATA_WIDTH-1:0]   r_mem [RAM_WORDS];
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_in_ack;
    logic                    r_in_err;
    logic                    r_out_ack;
    logic                    r_out_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            logic [FIFO_BITS-1:0] r_wr_ptr;
            logic [FIFO_BITS-1:0] r_rd_ptr;
            logic [CNT_W-1:0]     r_cnt;
            logic                 r_ovf;
            logic                 r_unf;

            // Requests issued while rst is high never select a channel.
            assign w_push_sel[gi]    = !rst && in_data_en  && (in_chan  == CH_BITS'(gi));
            assign w_pop_sel[gi]     = !rst && out_data_en && (out_chan == CH_BITS'(gi));
            assign w_full[gi]        = (r_cnt == CNT_W'(DEPTH));
            assign w_empty[gi]       = (r_cnt == '0);
            assign w_push_ok_vec[gi] = w_push_sel[gi] && !w_full[gi]  && !flush[gi];
            assign w_pop_ok_vec[gi]  = w_pop_sel[gi]  && !w_empty[gi] && !flush[gi];

            assign w_wr_ptr[gi] = r_wr_ptr;
            assign w_rd_ptr[gi] = r_rd_ptr;
            assign count[gi*CNT_W +: CNT_W] = r_cnt;
            assign full[gi]   = w_full[gi];
            assign empty[gi]  = w_empty[gi];
            assign afull[gi]  = (r_cnt >= CNT_W'(AF_LEVEL));
            assign aempty[gi] = (r_cnt <= CNT_W'(AE_LEVEL));
            assign ovf[gi]    = r_ovf;
            assign unf[gi]    = r_unf;

            always_ff @(posedge clk) begin
                if (rst || flush[gi]) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                    r_ovf    <= 1'b0;
                    r_unf    <= 1'b0;
                end else begin
                    if (w_push_ok_vec[gi]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop_ok_vec[gi]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    if (w_push_sel[gi] && w_full[gi]) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_pop_sel[gi] && w_empty[gi]) begin
                        r_unf <= 1'b1;
                    end
                    case ({w_push_ok_vec[gi], w_pop_ok_vec[gi]})
                        2'b10:   r_cnt <= r_cnt + 1'b1;
                        2'b01:   r_cnt <= r_cnt - 1'b1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

    assign w_push_ok = |w_push_ok_vec;
    assign w_pop_ok  = |w_pop_ok_vec;

    always_comb begin
        w_wr_ptr_sel = '0;
        w_rd_ptr_sel = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_push_sel[c]) begin
                w_wr_ptr_sel = w_wr_ptr[c];
            end
            if (w_pop_sel[c]) begin
                w_rd_ptr_sel = w_rd_ptr[c];
            end
        end
    end

    assign w_wr_addr = {in_chan, w_wr_ptr_sel};
    assign w_rd_addr = {out_chan, w_rd_ptr_sel};

    // A same-channel push and pop never share an address: the pop needs a
    // non-empty channel and the push a non-full one, so the pointers differ.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_addr] <= in_data;
        end
        if (w_pop_ok) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ack  <= 1'b0;
            r_in_err  <= 1'b0;
            r_out_ack <= 1'b0;
            r_out_err <= 1'b0;
        end else begin
            r_in_ack  <= in_data_en;
            r_in_err  <= in_data_en && !w_push_ok;
            r_out_ack <= out_data_en;
            r_out_err <= out_data_en && !w_pop_ok;
        end
    end

    assign in_data_ack  = r_in_ack;
    assign in_err       = r_in_err;
    assign out_data_ack = r_out_ack;
    assign out_err      = r_out_err;
    assign out_data     = (r_out_ack && !r_out_err) ? r_rd_data : '0;

endmodule

// File: tb/tb_fpio_fifo_mc.sv
// Directed and random stimulus for fpio_fifo_mc, checked against a queue-per-channel
// reference model.
module tb_fpio_fifo_mc;

    localparam int FB    = 4;
    localparam int DW    = 32;
    localparam int NC    = 4;
    localparam int CB    = 2;
    localparam int DEPTH = 16;
    localparam int CW    = FB + 1;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_data_en;
    logic [CB-1:0]     in_chan;
    logic [DW-1:0]     in_data;
    logic              in_data_ack;
    logic              in_err;
    logic              out_data_en;
    logic [CB-1:0]     out_chan;
    logic [DW-1:0]     out_data;
    logic              out_data_ack;
    logic              out_err;
    logic [NC-1:0]     flush;
    logic [NC*CW-1:0]  count;
    logic [NC-1:0]     full, empty, afull, aempty, ovf, unf;

    fpio_fifo_mc #(
        .FIFO_BITS(FB), .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data_en(in_data_en), .in_chan(in_chan), .in_data(in_data),
        .in_data_ack(in_data_ack), .in_err(in_err),
        .out_data_en(out_data_en), .out_chan(out_chan), .out_data(out_data),
        .out_data_ack(out_data_ack), .out_err(out_err),
        .flush(flush), .count(count),
        .full(full), .empty(empty), .afull(afull), .aempty(aempty),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] q [NC][$];
    logic [NC-1:0] m_ovf, m_unf;
    logic          e_in_ack, e_in_err, e_out_ack, e_out_err;
    logic [DW-1:0] e_out_data;
    logic [DW-1:0] saved [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [NC*CW-1:0] e_count;
        logic [NC-1:0]    e_full, e_empty, e_afull, e_aempty;
        for (int c = 0; c < NC; c++) begin
            int sz = q[c].size();
            e_count[c*CW +: CW] = CW'(sz);
            e_full[c]   = (sz == DEPTH);
            e_empty[c]  = (sz == 0);
            e_afull[c]  = (sz >= AF);
            e_aempty[c] = (sz <= AE);
        end
        chk("in_ack", in_data_ack, e_in_ack);
        chk("in_err", in_err, e_in_err);
        chk("out_ack", out_data_ack, e_out_ack);
        chk("out_err", out_err, e_out_err);
        if (e_out_ack) chk("out_data", out_data, e_out_data);
        chk("count", count, e_count);
        chk("full", full, e_full);
        chk("empty", empty, e_empty);
        chk("afull", afull, e_afull);
        chk("aempty", aempty, e_aempty);
        chk("ovf", ovf, m_ovf);
        chk("unf", unf, m_unf);
    endtask

    task automatic idle_inputs();
        in_data_en  = 1'b0;
        out_data_en = 1'b0;
        flush       = '0;
    endtask

    task automatic step(input bit pe, input int pc, input logic [DW-1:0] pd,
                        input bit oe, input int oc, input logic [NC-1:0] fl);
        bit push_ok, pop_ok;
        in_data_en  = pe;
        in_chan     = CB'(pc);
        in_data     = pd;
        out_data_en = oe;
        out_chan    = CB'(oc);
        flush       = fl;
        // Full/empty judged on occupancy before this cycle.
        push_ok = pe && !fl[pc] && (q[pc].size() < DEPTH);
        pop_ok  = oe && !fl[oc] && (q[oc].size() > 0);
        e_in_ack   = pe;
        e_in_err   = pe && !push_ok;
        e_out_ack  = oe;
        e_out_err  = oe && !pop_ok;
        e_out_data = '0;
        if (pop_ok) e_out_data = q[oc].pop_front();
        if (push_ok) q[pc].push_back(pd);
        if (pe && !push_ok && !fl[pc]) m_ovf[pc] = 1'b1;
        if (oe && !pop_ok && !fl[oc]) m_unf[oc] = 1'b1;
        for (int c = 0; c < NC; c++) begin
            if (fl[c]) begin
                q[c].delete();
                m_ovf[c] = 1'b0;
                m_unf[c] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
        check_all();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        in_data_en  = 1'b1;
        in_chan     = 2'd0;
        in_data     = 32'h1234_5678;
        out_data_en = 1'b1;
        out_chan    = 2'd0;
        flush       = '0;
        for (int c = 0; c < NC; c++) q[c].delete();
        m_ovf = '0;
        m_unf = '0;
        e_in_ack = 1'b0; e_in_err = 1'b0; e_out_ack = 1'b0; e_out_err = 1'b0;
        e_out_data = '0;
        @(posedge clk);
        #1;
        chk("rst_out_data", out_data, 32'h0);
        check_all();
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        in_chan = '0; out_chan = '0; in_data = '0;

        // Reset with requests held high: no acks, all channels empty.
        do_reset();
        do_reset();
        step(0, 0, 0, 0, 0, '0);

        // Ordered push/pop on channel 1.
        for (int i = 0; i < 4; i++) step(1, 1, 32'hA0 + i, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 1, '0);
            chk("ch1_pop_data", out_data, 32'hA0 + i);
        end
        chk("ch1_empty", empty[1], 1'b1);

        // Fill channel 0, overflow attempt, drain.
        for (int i = 0; i < DEPTH; i++) begin
            saved[i] = $urandom;
            step(1, 0, saved[i], 0, 0, '0);
        end
        chk("ch0_full", full[0], 1'b1);
        step(1, 0, 32'hDEAD, 0, 0, '0);
        chk("ovf_push_err", in_err, 1'b1);
        chk("ovf0_sticky", ovf[0], 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 1, 0, '0);
            chk("ch0_drain_data", out_data, saved[i]);
        end

        // Underflow on empty channel 2, then flush clears the sticky flag.
        step(0, 0, 0, 1, 2, '0);
        chk("unf_pop_err", out_err, 1'b1);
        chk("unf_pop_data", out_data, 32'h0);
        chk("unf2_set", unf[2], 1'b1);
        step(0, 0, 0, 0, 0, 4'b0100);
        chk("unf2_flushed", unf[2], 1'b0);

        // Push to empty channel with same-cycle pop: push wins, pop rejected.
        step(1, 2, 32'h55, 1, 2, '0);
        chk("empty_pushpop_err", out_err, 1'b1);
        step(0, 0, 0, 0, 0, 4'b0100);

        // Simultaneous push/pop on channel 3 at count 3, then pointer wrap.
        for (int i = 0; i < 3; i++) step(1, 3, 32'h300 + i, 0, 0, '0);
        step(1, 3, 32'h3FF, 1, 3, '0);
        chk("ch3_count_same", count[3*CW +: CW], 5'd3);
        chk("ch3_oldest", out_data, 32'h300);
        for (int i = 0; i < 2 * DEPTH; i++) step(1, 3, $urandom, 1, 3, '0);

        // Flush takes priority over a same-cycle push to the same channel.
        step(1, 3, 32'h77, 0, 0, 4'b1000);
        chk("flush_push_err", in_err, 1'b1);
        chk("flush_no_ovf", ovf[3], 1'b0);

        // Interleaved channel 0/1 fill past the almost-full level, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 32'h1000 + i, 0, 0, '0);
            step(1, 1, 32'h2000 + i, 0, 0, '0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 1, 1, '0);
            step(0, 0, 0, 1, 0, '0);
            chk("ch0_interleave", out_data, 32'h1000 + i);
        end

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            logic [NC-1:0] fl;
            fl = '0;
            if ($urandom_range(0, 39) == 0) fl[$urandom_range(0, NC - 1)] = 1'b1;
            step($urandom_range(0, 9) < 6, $urandom_range(0, NC - 1), $urandom,
                 $urandom_range(0, 9) < 5, $urandom_range(0, NC - 1), fl);
        end

        // Mid-stream reset with channel 0 holding five entries.
        step(0, 0, 0, 0, 0, 4'b1111);
        for (int i = 0; i < 5; i++) step(1, 0, 32'h500 + i, 0, 0, '0);
        chk("pre_rst_count0", count[0 +: CW], 5'd5);
        do_reset();
        chk("post_rst_empty", empty, 4'b1111);
        step(0, 0, 0, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
